// File: rtl/wb_data_arbiter_pkg.sv
// Shared constants and state encoding for the Wishbone data-bus arbiter.
package wb_data_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int          ARB_MASTER_NUM = 4;
  localparam int          ARB_IDX_W      = $clog2(ARB_MASTER_NUM);
  localparam int          ARB_TIMEOUT    = 255;
  localparam logic [31:0] ARB_ERR_DATA   = 32'hDEADBEEF;
  localparam int          ARB_TIMER_W    = 8;

endpackage

// File: rtl/wb_data_arbiter_picker.sv
// Round-robin priority picker: first set request at or after ptr, with wrap.
module rr_priority_picker #(
  parameter int NUM_MASTERS = 4,
  parameter int IW          = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] req_i,
  input  logic [IW-1:0]          ptr_i,
  output logic [NUM_MASTERS-1:0] gnt_o,
  output logic [IW-1:0]          idx_o,
  output logic                   any_o
);

  always_comb begin
    int k;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      // Explicit wrap so non-power-of-two master counts scan correctly.
      k = int'(ptr_i) + i;
      if (k >= NUM_MASTERS) k = k - NUM_MASTERS;
      if (!any_o && req_i[k]) begin
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_data_arbiter.sv
// Round-robin arbiter sharing one Wishbone data slave among several CPU
// data ports, with ack/data routing back to the owner and a bus timeout.
module wb_data_arbiter
  import wb_data_arbiter_pkg::*;
#(
  parameter int              NUM_MASTERS = ARB_MASTER_NUM,
  parameter int              DW          = 32,
  parameter int              TIMEOUT     = ARB_TIMEOUT,
  parameter logic [DW-1:0]   ERR_DATA    = DW'(ARB_ERR_DATA)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS*DW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [DW-1:0]             m_dat_o,
  output logic                      s_cyc_o,
  output logic                      s_we_o,
  output logic [DW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  output logic [NUM_MASTERS-1:0]    grant_o,
  output logic                      err_o
);

  localparam int                     IW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0]          LAST_IDX = IW'(NUM_MASTERS - 1);
  localparam logic [ARB_TIMER_W-1:0] TMAX     = ARB_TIMER_W'(TIMEOUT - 1);

  arb_state_e               state_q, state_d;
  logic [NUM_MASTERS-1:0]   grant_q, grant_d;
  logic [IW-1:0]            gidx_q, gidx_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic [ARB_TIMER_W-1:0]   timer_q, timer_d;
  logic                     err_q, err_d;

  logic [NUM_MASTERS-1:0]   pick_gnt;
  logic [IW-1:0]            pick_idx;
  logic                     pick_any;

  logic busy, own_cyc, ack_ok, to_hit, done;

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS),
    .IW          (IW)
  ) u_picker (
    .req_i (m_cyc_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign busy    = (state_q == ARB_BUSY);
  assign own_cyc = m_cyc_i[gidx_q];
  // A real ack wins over a timeout landing in the same cycle.
  assign ack_ok  = busy & own_cyc & s_ack_i;
  assign to_hit  = busy & own_cyc & ~s_ack_i & (timer_q == TMAX);
  assign done    = busy & (ack_ok | to_hit | ~own_cyc);

  always_comb begin
    s_cyc_o = busy & own_cyc & ~to_hit;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (busy) begin
      s_we_o  = m_we_i[gidx_q];
      s_adr_o = m_adr_i[int'(gidx_q)*DW +: DW];
      s_dat_o = m_dat_i[int'(gidx_q)*DW +: DW];
    end
    m_ack_o = (ack_ok | to_hit) ? grant_q : '0;
    m_dat_o = ack_ok ? s_dat_i : (to_hit ? ERR_DATA : '0);
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    err_d   = err_q;
    case (state_q)
      ARB_IDLE: begin
        timer_d = '0;
        if (pick_any) begin
          state_d = ARB_BUSY;
          grant_d = pick_gnt;
          gidx_d  = pick_idx;
        end
      end
      ARB_BUSY: begin
        // Always return to IDLE after an access so cores can drop cyc.
        if (done) begin
          state_d = ARB_IDLE;
          grant_d = '0;
          timer_d = '0;
          ptr_d   = (gidx_q == LAST_IDX) ? '0 : gidx_q + 1'b1;
          err_d   = err_q | to_hit;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign grant_o = grant_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_wb_data_arbiter.sv
// Directed, table-driven bench for wb_data_arbiter (4 masters, TIMEOUT=8).
module tb_wb_data_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    m_cyc_i, m_we_i, m_ack_o, grant_o;
  logic [N*DW-1:0] m_adr_i, m_dat_i;
  logic [DW-1:0]   m_dat_o, s_adr_o, s_dat_o, s_dat_i;
  logic            s_cyc_o, s_we_o, s_ack_i, err_o;

  always #5 clk = ~clk;

  wb_data_arbiter #(
    .NUM_MASTERS (N),
    .DW          (DW),
    .TIMEOUT     (8),
    .ERR_DATA    (32'hDEADBEEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .m_cyc_i (m_cyc_i),
    .m_we_i  (m_we_i),
    .m_adr_i (m_adr_i),
    .m_dat_i (m_dat_i),
    .m_ack_o (m_ack_o),
    .m_dat_o (m_dat_o),
    .s_cyc_o (s_cyc_o),
    .s_we_o  (s_we_o),
    .s_adr_o (s_adr_o),
    .s_dat_o (s_dat_o),
    .s_dat_i (s_dat_i),
    .s_ack_i (s_ack_i),
    .grant_o (grant_o),
    .err_o   (err_o)
  );

  typedef struct {
    logic        rst;
    logic [3:0]  cyc;
    logic        ack;
    logic [31:0] sdat;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic [31:0] e_mdat;
    logic        e_scyc;
    logic        e_swe;
    logic [31:0] e_sadr;
    logic [31:0] e_sdat;
    logic        e_err;
  } vec_t;

  logic [31:0] adr_tab [N] = '{32'h0000_0040, 32'h0000_0100, 32'h0000_2000, 32'h0000_3000};
  logic [31:0] dat_tab [N] = '{32'h0A0A_0A0A, 32'h1111_1111, 32'hA5A5_A5A5, 32'h3333_3333};
  logic [3:0]  we_fix      = 4'b0100;

  int n_vec = 0;
  int n_bad = 0;

  // Slave-side address/data/we are implied by which slot the vector expects granted.
  function automatic vec_t mk(input logic r, input logic [3:0] cyc, input logic ack,
                              input logic [31:0] sdat, input logic [3:0] eg,
                              input logic [3:0] ea, input logic [31:0] em,
                              input logic es, input logic ee);
    vec_t v;
    v.rst = r; v.cyc = cyc; v.ack = ack; v.sdat = sdat;
    v.e_grant = eg; v.e_ack = ea; v.e_mdat = em; v.e_scyc = es; v.e_err = ee;
    v.e_swe = 1'b0; v.e_sadr = '0; v.e_sdat = '0;
    for (int k = 0; k < N; k++) begin
      if (eg[k]) begin
        v.e_swe  = we_fix[k];
        v.e_sadr = adr_tab[k];
        v.e_sdat = dat_tab[k];
      end
    end
    return v;
  endfunction

  task automatic apply(input vec_t v, input string nm);
    @(negedge clk);
    rst     = v.rst;
    m_cyc_i = v.cyc;
    s_ack_i = v.ack;
    s_dat_i = v.sdat;
    #1;
    n_vec++;
    if (grant_o !== v.e_grant || m_ack_o !== v.e_ack || m_dat_o !== v.e_mdat ||
        s_cyc_o !== v.e_scyc || s_we_o !== v.e_swe || s_adr_o !== v.e_sadr ||
        s_dat_o !== v.e_sdat || err_o !== v.e_err) begin
      n_bad++;
      $display("FAIL %s: got grant=%b ack=%b mdat=%h scyc=%b swe=%b sadr=%h sdat=%h err=%b; want grant=%b ack=%b mdat=%h scyc=%b swe=%b sadr=%h sdat=%h err=%b",
               nm, grant_o, m_ack_o, m_dat_o, s_cyc_o, s_we_o, s_adr_o, s_dat_o, err_o,
               v.e_grant, v.e_ack, v.e_mdat, v.e_scyc, v.e_swe, v.e_sadr, v.e_sdat, v.e_err);
    end
  endtask

  vec_t tbl [24];

  initial begin
    rst     = 1'b0;
    m_cyc_i = '0;
    s_ack_i = 1'b0;
    s_dat_i = '0;
    m_we_i  = we_fix;
    for (int k = 0; k < N; k++) begin
      m_adr_i[k*DW +: DW] = adr_tab[k];
      m_dat_i[k*DW +: DW] = dat_tab[k];
    end
    repeat (3) @(posedge clk);

    // Reset state, single read by core1 acked on the third BUSY cycle.
    tbl[0]  = mk(0, 4'b0000, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[1]  = mk(1, 4'b0010, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[2]  = mk(1, 4'b0010, 0, 32'h0,          4'b0010, 4'b0000, 32'h0,          1, 0);
    tbl[3]  = mk(1, 4'b0010, 0, 32'h0,          4'b0010, 4'b0000, 32'h0,          1, 0);
    tbl[4]  = mk(1, 4'b0010, 1, 32'h1234_5678,  4'b0010, 4'b0010, 32'h1234_5678,  1, 0);
    tbl[5]  = mk(1, 4'b0000, 1, 32'h1234_5678,  4'b0000, 4'b0000, 32'h0,          0, 0);
    // Write routing: ptr=2, cores 2 and 3 request; core2 first, then core3.
    tbl[6]  = mk(1, 4'b1100, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[7]  = mk(1, 4'b1100, 1, 32'h0,          4'b0100, 4'b0100, 32'h0,          1, 0);
    tbl[8]  = mk(1, 4'b1000, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[9]  = mk(1, 4'b1000, 1, 32'hCAFE_F00D,  4'b1000, 4'b1000, 32'hCAFE_F00D,  1, 0);
    // Round-robin with every core requesting and an always-acking slave.
    tbl[10] = mk(1, 4'b1111, 1, 32'h1000_000A,  4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[11] = mk(1, 4'b1111, 1, 32'h1000_000B,  4'b0001, 4'b0001, 32'h1000_000B,  1, 0);
    tbl[12] = mk(1, 4'b1111, 1, 32'h1000_000C,  4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[13] = mk(1, 4'b1111, 1, 32'h1000_000D,  4'b0010, 4'b0010, 32'h1000_000D,  1, 0);
    tbl[14] = mk(1, 4'b1111, 1, 32'h1000_000E,  4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[15] = mk(1, 4'b1111, 1, 32'h1000_000F,  4'b0100, 4'b0100, 32'h1000_000F,  1, 0);
    tbl[16] = mk(1, 4'b1111, 1, 32'h1000_0010,  4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[17] = mk(1, 4'b1111, 1, 32'h1000_0011,  4'b1000, 4'b1000, 32'h1000_0011,  1, 0);
    tbl[18] = mk(1, 4'b1111, 1, 32'h1000_0012,  4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[19] = mk(1, 4'b1111, 1, 32'h1000_0013,  4'b0001, 4'b0001, 32'h1000_0013,  1, 0);
    // Abort: core0 drops cyc mid-access; a concurrent s_ack_i must not ack it.
    tbl[20] = mk(1, 4'b0001, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          0, 0);
    tbl[21] = mk(1, 4'b0001, 0, 32'h0,          4'b0001, 4'b0000, 32'h0,          1, 0);
    tbl[22] = mk(1, 4'b0000, 1, 32'h7777_7777,  4'b0001, 4'b0000, 32'h0,          0, 0);
    tbl[23] = mk(1, 4'b0000, 0, 32'h0,          4'b0000, 4'b0000, 32'h0,          0, 0);

    for (int i = 0; i < 24; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));

    // Ack arriving exactly on the timeout cycle (ptr=1, core1).
    apply(mk(1, 4'b0010, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 0), "race_req");
    for (int i = 0; i < 7; i++)
      apply(mk(1, 4'b0010, 0, 32'h0, 4'b0010, 4'b0000, 32'h0, 1, 0), "race_wait");
    apply(mk(1, 4'b0010, 1, 32'h600D_600D, 4'b0010, 4'b0010, 32'h600D_600D, 1, 0), "race_ack");
    apply(mk(1, 4'b0000, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 0), "race_noerr");

    // Timeout on core0 (ptr=2 scans 2,3,0).
    apply(mk(1, 4'b0001, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 0), "to_req");
    for (int i = 0; i < 7; i++)
      apply(mk(1, 4'b0001, 0, 32'h0, 4'b0001, 4'b0000, 32'h0, 1, 0), "to_wait");
    apply(mk(1, 4'b0001, 0, 32'h5555_5555, 4'b0001, 4'b0001, 32'hDEAD_BEEF, 0, 0), "to_fire");
    apply(mk(1, 4'b0011, 0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 1), "to_err");
    apply(mk(1, 4'b0011, 0, 32'h0, 4'b0010, 4'b0000, 32'h0, 1, 1), "to_ptr1");

    // Reset mid-access, then a stale ack, then arbitration restarts at ptr=0.
    apply(mk(0, 4'b0011, 0, 32'h0, 4'b0010, 4'b0000, 32'h0, 1, 1), "rst_assert");
    apply(mk(1, 4'b0011, 1, 32'hBAD0_BAD0, 4'b0000, 4'b0000, 32'h0, 0, 0), "rst_stale_ack");
    apply(mk(1, 4'b0011, 0, 32'h0, 4'b0001, 4'b0000, 32'h0, 1, 0), "rst_ptr0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/wb_data_arbiter.md
Name: wb_data_arbiter

Overview:
- Round-robin arbiter sharing one Wishbone data-bus slave (data RAM / peripheral fabric) among NUM_MASTERS j1 CPU cores.
- Each core's data port (cyc_o/we_o/adr_o/dat_o, ack_i/dat_i) connects to one master slot.
- The arbiter serialises accesses, routes ack and read data back to the owning core, and enforces a bus timeout so that a dead slave cannot stall every core.

Parameters:
- NUM_MASTERS, 4, number of CPU data ports (2..8).
- DW, 32, data and address width (matches `DataWidth).
- TIMEOUT, 255, maximum cycles a granted access waits for s_ack_i before forced termination (1..255).
- ERR_DATA, 32'hDEADBEEF, read data returned on a timed-out access.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-low
- m_cyc_i  input  NUM_MASTERS  per-core bus request (level, held until ack)
- m_we_i  input  NUM_MASTERS  per-core write enable
- m_adr_i  input  NUM_MASTERS*DW  per-core address, slot k at [k*DW +: DW]
- m_dat_i  input  NUM_MASTERS*DW  per-core write data
- m_ack_o  output  NUM_MASTERS  per-core ack, one-cycle pulse
- m_dat_o  output  DW  read data, broadcast to all cores, valid with m_ack_o
- s_cyc_o  output  1  slave cycle/strobe
- s_we_o  output  1  slave write enable
- s_adr_o  output  DW  slave address
- s_dat_o  output  DW  slave write data
- s_dat_i  input  DW  slave read data
- s_ack_i  input  1  slave ack
- grant_o  output  NUM_MASTERS  one-hot current owner, all zero when idle
- err_o  output  1  sticky timeout flag; cleared only by reset

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, grant_o=0, rr pointer=0, timer=0, err_o=0.
  - Combinational outputs then read: s_cyc_o=0, s_we_o=0, s_adr_o=0, s_dat_o=0, m_ack_o=0, m_dat_o=0.
  - Reset mid-access abandons the access with no ack.
- States:
  - IDLE→BUSY when any m_cyc_i is set.
  - BUSY→IDLE on s_ack_i, owner abort, or timeout.
- Arbitration in IDLE:
  - The winner is the first set m_cyc_i bit scanning from index ptr upward, with wrap-around.
  - grant_o and state are registered at the next edge, so there is 1 cycle from request to s_cyc_o.
- BUSY outputs:
  - s_cyc_o=1.
  - s_we_o, s_adr_o, s_dat_o are muxed combinationally from the granted slot.
- Ack path, combinational, same cycle:
  - m_ack_o[g] = s_ack_i & s_cyc_o.
  - m_dat_o = s_dat_i when m_ack_o is nonzero, else 0.
  - s_ack_i in IDLE is ignored.
- Completion:
  - On ack, next edge: state=IDLE, grant_o=0, ptr=(g+1) mod NUM_MASTERS.
  - No back-to-back grant: there is always at least one IDLE cycle. This lets cores drop cyc after ack, since core cyc is combinational and would otherwise be re-sampled stale.
- Abort:
  - If m_cyc_i[g] drops while BUSY with no s_ack_i, then next edge: IDLE, no ack, ptr=(g+1).
  - s_cyc_o follows m_cyc_i[g] combinationally in that cycle (s_cyc_o = busy & m_cyc_i[g]).
- Timeout:
  - timer increments each BUSY cycle without ack.
  - When timer==TIMEOUT-1 and s_ack_i==0: m_ack_o[g]=1, m_dat_o=ERR_DATA, s_cyc_o=0 in that cycle.
  - Next edge: err_o=1, IDLE, ptr advances.
  - timer clears on entering IDLE.
- Simultaneous events:
  - s_ack_i in the timeout cycle is treated as a normal ack; m_dat_o=s_dat_i and err_o is not set.
  - Requests arriving while BUSY wait; no requests are dropped.
- Fairness: with all cores requesting, grants rotate 0,1,2,3,0…; worst-case wait is (NUM_MASTERS-1) accesses.
- Width rules:
  - ptr and grant index are $clog2(NUM_MASTERS) bits, and the wrap is explicit (not relying on a power of two).
  - timer is 8 bits.

Decomposition:
- define.v gains:
  - `ArbMasterNum (default 4)
  - `ArbIdxWidth
  - `ArbTimeout
  - `ArbErrData
  - state encodings `ArbIdle=1'b0, `ArbBusy=1'b1
- One sub-module: rr_priority_picker.
  - Inputs: req[NUM_MASTERS], ptr.
  - Outputs: one-hot gnt, binary idx, any.
  - Purely combinational, verified standalone.

Test Plan:
- Single read: core1 m_cyc_i=1, adr=0x100, we=0; slave acks 2 cycles after s_cyc_o with 0x12345678 → s_adr_o=0x100, grant_o=0010, m_ack_o=0010 for one cycle with m_dat_o=0x12345678, then idle ≥1 cycle.
- Round-robin: all 4 cores request continuously, slave acks immediately → grant order 0,1,2,3,0; every grant separated by one idle cycle; each core gets exactly 1 of every 4 acks.
- Write routing: core2 we=1, adr=0x2000, dat=0xA5A5A5A5 while core3 also requests, ptr=2 → core2 wins; s_we_o=1, s_dat_o=0xA5A5A5A5; core3 granted next.
- Timeout: TIMEOUT=8, slave never acks to core0 → m_ack_o[0] pulses in the 8th BUSY cycle with m_dat_o=0xDEADBEEF, err_o=1 thereafter, ptr=1.
- Abort/ack race: core0 drops cyc mid-BUSY → no ack, IDLE next cycle. Separately, s_ack_i arrives exactly on the timeout cycle → normal data returned and err_o stays 0.
- Reset mid-access: rst=0 during BUSY → next edge grant_o=0, s_cyc_o=0, err_o=0, ptr=0; a stale s_ack_i afterwards produces no m_ack_o.
